// File: rtl/spi_bus_bridge_pkg.sv
// Shared opcodes, FSM state type and status-byte layout for the SPI-to-bus bridge.
package spi_bus_bridge_pkg;

  localparam logic [7:0] OP_WRITE      = 8'h01;
  localparam logic [7:0] OP_READ       = 8'h02;
  localparam logic [7:0] OP_WRITE_NEXT = 8'h03;
  localparam logic [7:0] OP_READ_NEXT  = 8'h04;
  localparam logic [7:0] OP_CLEAR_ERR  = 8'h05;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    REQ  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam int STATUS_BUSY_BIT  = 7;
  localparam int STATUS_ERROR_BIT = 6;
  localparam int STATUS_RDV_BIT   = 5;

  function automatic logic [7:0] status_byte(input logic busy, input logic error,
                                             input logic rd_valid);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_BUSY_BIT]  = busy;
    s[STATUS_ERROR_BIT] = error;
    s[STATUS_RDV_BIT]   = rd_valid;
    return s;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 slave byte engine: synchronises the pins, shifts MOSI in on rising
// sclk, shifts the response out on falling sclk and flags each completed byte.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       rx,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       tx
);

  logic [2:0] sclk_sync_r;
  logic [1:0] cs_sync_r;
  logic [1:0] rx_sync_r;
  logic [7:0] rx_shift_r;
  logic [7:0] rx_byte_r;
  logic [7:0] tx_shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_valid_r;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_active_s;

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign cs_active_s = ~cs_sync_r[1];

  // Pin synchronisers, rx shifting, bit counting and tx shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_r  <= 3'b000;
      cs_sync_r    <= 2'b11;
      rx_sync_r    <= 2'b00;
      rx_shift_r   <= 8'h00;
      rx_byte_r    <= 8'h00;
      tx_shift_r   <= 8'h00;
      bit_cnt_r    <= 3'd0;
      byte_valid_r <= 1'b0;
    end else begin
      sclk_sync_r  <= {sclk_sync_r[1:0], sclk};
      cs_sync_r    <= {cs_sync_r[0], cs_n};
      rx_sync_r    <= {rx_sync_r[0], rx};
      byte_valid_r <= 1'b0;
      if (!cs_active_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        rx_shift_r <= {rx_shift_r[6:0], rx_sync_r[1]};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid_r <= 1'b1;
          rx_byte_r    <= {rx_shift_r[6:0], rx_sync_r[1]};
        end
      end
      // The falling edge that closes a byte must not disturb the freshly loaded response.
      if (tx_load) begin
        tx_shift_r <= tx_data;
      end else if (cs_active_s && sclk_fall_s && (bit_cnt_r != 3'd0)) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
    end
  end

  assign rx_byte    = rx_byte_r;
  assign byte_valid = byte_valid_r;
  assign tx         = cs_active_s & tx_shift_r[7];

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI-slave to req/ack system-bus bridge: command FSM and bus handshake.
// Optional bus_ack timeout is enabled by defining SPI_BUS_BRIDGE_TIMEOUT_EN.
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_rx,
  output logic                  spi_tx,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  input  logic [7:0]            bus_rd_data,
  output logic                  bus_rw_b,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  error
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int ABITS      = ADDR_BYTES * 8;
  localparam int CNT_W      = $clog2(ADDR_BYTES + 1);

  if (DATA_WIDTH != 8) begin : g_dw_check
    $error("spi_bus_bridge: DATA_WIDTH must be 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("spi_bus_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_r, state_n;
  logic [ABITS-1:0]      acc_r, acc_n;
  logic [CNT_W-1:0]      addr_cnt_r, addr_cnt_n;
  logic [ADDR_WIDTH-1:0] target_r, target_n;
  logic [ADDR_WIDTH-1:0] last_addr_r, last_addr_n;
  logic [ADDR_WIDTH-1:0] bus_addr_r, bus_addr_n;
  logic [7:0]            wr_data_r, wr_data_n;
  logic [7:0]            rd_data_r, rd_data_n;
  logic                  rw_b_r, rw_b_n;
  logic                  req_r, req_n;
  logic                  error_r, error_n;
  logic                  rd_valid_r, rd_valid_n;
  logic [7:0]            rx_byte_s;
  logic                  byte_valid_s;
  logic [7:0]            tx_data_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  assign next_addr_s = last_addr_r + ADDR_WIDTH'(1'b1);
  assign tx_data_s   = rd_valid_r ? rd_data_r : status_byte(state_r != IDLE, error_r, rd_valid_r);

  spi_byte_shifter u_shifter (
    .clk        (sys_clk),
    .reset      (reset),
    .sclk       (spi_sclk),
    .cs_n       (spi_cs_n),
    .rx         (spi_rx),
    .tx_load    (byte_valid_s),
    .tx_data    (tx_data_s),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .tx         (spi_tx)
  );

`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_n;
  logic          tmo_hit_s;
  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting in REQ.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_n;
    end
  end
`endif

  // Next-state and datapath decisions for the command FSM.
  always_comb begin
    state_n     = state_r;
    acc_n       = acc_r;
    addr_cnt_n  = addr_cnt_r;
    target_n    = target_r;
    last_addr_n = last_addr_r;
    bus_addr_n  = bus_addr_r;
    wr_data_n   = wr_data_r;
    rd_data_n   = rd_data_r;
    rw_b_n      = rw_b_r;
    req_n       = req_r;
    error_n     = error_r;
    if (byte_valid_s && rd_valid_r) begin
      rd_valid_n = 1'b0;
    end else begin
      rd_valid_n = rd_valid_r;
    end
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
    tmo_cnt_n = '0;
`endif
    case (state_r)
      IDLE: begin
        if (byte_valid_s) begin
          case (rx_byte_s)
            OP_WRITE, OP_READ: begin
              rw_b_n     = (rx_byte_s == OP_READ);
              acc_n      = '0;
              addr_cnt_n = '0;
              state_n    = ADDR;
            end
            OP_WRITE_NEXT: begin
              rw_b_n   = 1'b0;
              target_n = next_addr_s;
              state_n  = DATA;
            end
            OP_READ_NEXT: begin
              rw_b_n     = 1'b1;
              bus_addr_n = next_addr_s;
              req_n      = 1'b1;
              state_n    = REQ;
            end
            OP_CLEAR_ERR: begin
              error_n = 1'b0;
            end
            default: begin
              error_n = 1'b1;
            end
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      ADDR: begin
        if (byte_valid_s) begin
          // Bytes shifted past the top of the accumulator drop the excess high bits.
          acc_n      = (acc_r << 4'd8) | ABITS'(rx_byte_s);
          addr_cnt_n = addr_cnt_r + CNT_W'(1'b1);
          if (addr_cnt_r == CNT_W'(ADDR_BYTES - 1)) begin
            target_n = acc_n[ADDR_WIDTH-1:0];
            if (rw_b_r) begin
              bus_addr_n = acc_n[ADDR_WIDTH-1:0];
              req_n      = 1'b1;
              state_n    = REQ;
            end else begin
              state_n = DATA;
            end
          end else begin
            state_n = ADDR;
          end
        end else begin
          state_n = ADDR;
        end
      end
      DATA: begin
        if (byte_valid_s) begin
          wr_data_n  = rx_byte_s;
          bus_addr_n = target_r;
          req_n      = 1'b1;
          state_n    = REQ;
        end else begin
          state_n = DATA;
        end
      end
      REQ: begin
        if (byte_valid_s) begin
          error_n = 1'b1;
        end else begin
          error_n = error_r;
        end
        if (bus_ack) begin
          req_n       = 1'b0;
          last_addr_n = bus_addr_r;
          if (rw_b_r) begin
            rd_data_n  = bus_rd_data;
            rd_valid_n = 1'b1;
            state_n    = RESP;
          end else begin
            state_n = IDLE;
          end
        end else begin
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
          if (tmo_hit_s) begin
            req_n   = 1'b0;
            error_n = 1'b1;
            state_n = IDLE;
            if (rw_b_r) begin
              rd_data_n  = 8'hFF;
              rd_valid_n = 1'b1;
            end else begin
              rd_valid_n = rd_valid_r;
            end
          end else begin
            tmo_cnt_n = tmo_cnt_r + TW'(1'b1);
          end
`else
          state_n = REQ;
`endif
        end
      end
      RESP: begin
        if (byte_valid_s) begin
          error_n = 1'b1;
        end else begin
          error_n = error_r;
        end
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  // Command FSM and bus-side registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      addr_cnt_r  <= '0;
      target_r    <= '0;
      last_addr_r <= '0;
      bus_addr_r  <= '0;
      wr_data_r   <= 8'h00;
      rd_data_r   <= 8'h00;
      rw_b_r      <= 1'b1;
      req_r       <= 1'b0;
      error_r     <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      acc_r       <= acc_n;
      addr_cnt_r  <= addr_cnt_n;
      target_r    <= target_n;
      last_addr_r <= last_addr_n;
      bus_addr_r  <= bus_addr_n;
      wr_data_r   <= wr_data_n;
      rd_data_r   <= rd_data_n;
      rw_b_r      <= rw_b_n;
      req_r       <= req_n;
      error_r     <= error_n;
      rd_valid_r  <= rd_valid_n;
    end
  end

  assign bus_addr    = bus_addr_r;
  assign bus_wr_data = wr_data_r;
  assign bus_rw_b    = rw_b_r;
  assign bus_req     = req_r;
  assign busy        = (state_r != IDLE);
  assign error       = error_r;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Scoreboard bench for spi_bus_bridge: SPI host model, bus responder, MISO checks.
`timescale 1ns/1ps
module tb_spi_bus_bridge;

  localparam int HALF = 80;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_cs_n, spi_rx, spi_tx;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data, bus_rd_data;
  logic        bus_rw_b, bus_req, bus_ack, busy, error;

  typedef struct packed {
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] m;

  always #5 sys_clk = ~sys_clk;

  spi_bus_bridge #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_rx(spi_rx), .spi_tx(spi_tx),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rw_b(bus_rw_b), .bus_req(bus_req), .bus_ack(bus_ack),
    .busy(busy), .error(error)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_hi();
    #(HALF);
    spi_cs_n = 1'b1;
    #(HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] mosi, output logic [7:0] miso);
    for (int i = 7; i >= 0; i--) begin
      spi_rx = mosi[i];
      #(HALF);
      miso[i] = spi_tx;
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
    #(HALF);
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_rx = ~i[0];
      #(HALF);
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] unused;
    spi_xfer(b, unused);
  endtask

  // Wait (bounded) for bus_req, then compare against the scoreboard head.
  task automatic expect_req(input string tag);
    int   n;
    txn_t e;
    n = 0;
    @(negedge sys_clk);
    while (!bus_req && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check_value({tag, "_req"}, 32'(bus_req), 32'd1);
    check_value({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_value({tag, "_addr"}, 32'(bus_addr), 32'(e.addr));
      check_value({tag, "_rw"}, 32'(bus_rw_b), 32'(e.rw));
      if (!e.rw) begin
        check_value({tag, "_wdata"}, 32'(bus_wr_data), 32'(e.data));
      end
    end
  endtask

  task automatic do_ack(input string tag, input logic [7:0] rd, input logic is_read);
    repeat (3) @(negedge sys_clk);
    bus_ack = 1'b1;
    bus_rd_data = rd;
    @(negedge sys_clk);
    bus_ack = 1'b0;
    check_value({tag, "_req_drop"}, 32'(bus_req), 32'd0);
    check_value({tag, "_busy_after_ack"}, 32'(busy), 32'(is_read));
    @(negedge sys_clk);
    check_value({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #(2ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_rx = 1'b0;
    bus_ack = 1'b0; bus_rd_data = 8'h00;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check_value("rst_req", 32'(bus_req), 32'd0);
    check_value("rst_rw", 32'(bus_rw_b), 32'd1);
    check_value("rst_addr", 32'(bus_addr), 32'd0);
    check_value("rst_wdata", 32'(bus_wr_data), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_error", 32'(error), 32'd0);
    check_value("rst_tx", 32'(spi_tx), 32'd0);

    // Plain write.
    exp_q.push_back('{rw: 1'b0, addr: 17'h12345, data: 8'hA5});
    cs_lo(); send(8'h01); send(8'h01); send(8'h23); send(8'h45); send(8'hA5); cs_hi();
    expect_req("wr");
    do_ack("wr", 8'h00, 1'b0);

    // Auto-increment write from the previous address.
    exp_q.push_back('{rw: 1'b0, addr: 17'h12346, data: 8'h11});
    cs_lo(); send(8'h03); send(8'h11); cs_hi();
    expect_req("wrn");
    do_ack("wrn", 8'h00, 1'b0);

    // Excess top-byte bits are ignored.
    exp_q.push_back('{rw: 1'b0, addr: 17'h00001, data: 8'h5A});
    cs_lo(); send(8'h01); send(8'hFE); send(8'h00); send(8'h01); send(8'h5A); cs_hi();
    expect_req("wrx");
    do_ack("wrx", 8'h00, 1'b0);

    // Read, then dummy bytes to fetch data and status.
    exp_q.push_back('{rw: 1'b1, addr: 17'h08000, data: 8'h00});
    cs_lo(); send(8'h02); send(8'h00); send(8'h80); send(8'h00); cs_hi();
    expect_req("rd");
    do_ack("rd", 8'h5C, 1'b1);
    cs_lo();
    spi_xfer(8'h05, m);
    check_value("rd_status_busy", 32'(m), 32'h80);
    spi_xfer(8'h05, m);
    check_value("rd_data", 32'(m), 32'h5C);
    spi_xfer(8'h05, m);
    check_value("rd_status_after", 32'(m), 32'h00);
    cs_hi();

    // Address wrap on READ_NEXT.
    exp_q.push_back('{rw: 1'b0, addr: 17'h1FFFF, data: 8'h77});
    cs_lo(); send(8'h01); send(8'h01); send(8'hFF); send(8'hFF); send(8'h77); cs_hi();
    expect_req("wrtop");
    do_ack("wrtop", 8'h00, 1'b0);
    exp_q.push_back('{rw: 1'b1, addr: 17'h00000, data: 8'h00});
    cs_lo(); send(8'h04); cs_hi();
    expect_req("rdn");
    do_ack("rdn", 8'h9A, 1'b1);
    cs_lo(); send(8'h05); spi_xfer(8'h05, m); cs_hi();
    check_value("rdn_data", 32'(m), 32'h9A);

    // Bad opcode and error clear.
    cs_lo(); send(8'h7E);
    check_value("bad_op_error", 32'(error), 32'd1);
    send(8'h05);
    spi_xfer(8'h05, m);
    cs_hi();
    check_value("bad_op_status", 32'(m), 32'h40);
    check_value("clear_err", 32'(error), 32'd0);

    // Partial byte discarded on cs_n, then reset during REQ.
    exp_q.push_back('{rw: 1'b0, addr: 17'h00007, data: 8'h3C});
    cs_lo(); send(8'h01); spi_bits(4); cs_hi();
    cs_lo(); send(8'h00); send(8'h00); send(8'h07); send(8'h3C); cs_hi();
    expect_req("part");
    @(negedge sys_clk);
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    check_value("mid_rst_req", 32'(bus_req), 32'd0);
    check_value("mid_rst_busy", 32'(busy), 32'd0);
    check_value("mid_rst_addr", 32'(bus_addr), 32'd0);
    check_value("mid_rst_rw", 32'(bus_rw_b), 32'd1);
    check_value("mid_rst_wdata", 32'(bus_wr_data), 32'd0);
    check_value("mid_rst_error", 32'(error), 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
    begin
      int cnt;
      exp_q.push_back('{rw: 1'b1, addr: 17'h00010, data: 8'h00});
      cs_lo(); send(8'h02); send(8'h00); send(8'h00); send(8'h10); cs_hi();
      expect_req("tmo");
      cnt = 1;
      @(negedge sys_clk);
      while (bus_req && cnt < 100) begin
        cnt++;
        @(negedge sys_clk);
      end
      check_value("tmo_cycles", 32'(cnt), 32'd16);
      check_value("tmo_error", 32'(error), 32'd1);
      cs_lo(); send(8'h05); spi_xfer(8'h05, m); cs_hi();
      check_value("tmo_data", 32'(m), 32'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
